// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the folded symmetric FIR sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Number of coefficient positions after folding the symmetric taps.
    function automatic int npair(input int tap);
        return (tap + 32'sd1) / 32'sd2;
    endfunction

    function automatic int acc_w(input int width, input int cof, input int tap);
        return width + 32'sd1 + cof + clog2(npair(tap));
    endfunction

endpackage

// File: rtl/fir_ring_buf.sv
// Sample history ring: one write port and two combinational read ports that
// fetch the symmetric pair (newest-k) and (newest-(TAP-1-k)) modulo TAP.
module fir_ring_buf
    import fir_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int TAP   = 101
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [clog2(TAP)-1:0]    wr_idx_i,
    input  logic signed [WIDTH-1:0]  wr_data_i,
    input  logic [clog2(TAP)-1:0]    newest_i,
    input  logic [5:0]               k_i,
    output logic signed [WIDTH-1:0]  a_o,
    output logic signed [WIDTH-1:0]  b_o
);

    localparam int PTR_W = clog2(TAP);
    localparam int IDX_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] TAP_L = IDX_W'(TAP);

    logic signed [WIDTH-1:0] ring_q [TAP];
    logic [IDX_W-1:0]        k_ext_s;
    logic [IDX_W-1:0]        mirror_s;
    logic [PTR_W-1:0]        idx_a_s;
    logic [PTR_W-1:0]        idx_b_s;

    // Wrap below zero by adding TAP once; offsets never exceed TAP-1.
    function automatic logic [PTR_W-1:0] wrap_sub(input logic [PTR_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W-1:0] base_ext;
        base_ext = {1'b0, base};
        if (base_ext >= off) begin
            return PTR_W'(base_ext - off);
        end else begin
            return PTR_W'(base_ext + TAP_L - off);
        end
    endfunction

    // Read addresses for the two taps of the current pair.
    always_comb begin
        k_ext_s  = IDX_W'(k_i);
        mirror_s = TAP_L - IDX_W'(1) - k_ext_s;
        idx_a_s  = wrap_sub(newest_i, k_ext_s);
        idx_b_s  = wrap_sub(newest_i, mirror_s);
    end

    assign a_o = ring_q[idx_a_s];
    assign b_o = ring_q[idx_b_s];

    // History storage, cleared by reset so filling starts from silence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAP; i++) begin
                ring_q[i] <= '0;
            end
        end else if (we_i) begin
            ring_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_fold_sched.sv
// Folded symmetric FIR sequencer: one pre-adder and one MAC shared over all
// coefficient pairs. Define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_fold_sched
    import fir_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int TAP   = 101,
    parameter int COF   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  sam_in,
    output logic [5:0]               coef_addr,
    input  logic signed [COF-1:0]    coef_data,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  data_out,
    output logic                     busy
);

    localparam int NPAIR = npair(TAP);
    localparam int ACC_W = acc_w(WIDTH, COF, TAP);
    localparam int PTR_W = clog2(TAP);
    localparam int PRE_W = WIDTH + 1;
    localparam logic [5:0]       K_LAST   = 6'(NPAIR - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAP - 1);

    fir_state_e              state_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        newest_q;
    logic [5:0]              k_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [WIDTH-1:0] data_out_q;
    logic                    out_valid_q;
    logic                    in_ready_q;
    logic                    busy_q;

    logic                    accept_s;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [PRE_W-1:0] pre_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [WIDTH-1:0] result_s;

    assign accept_s = (state_q == IDLE) && in_valid && in_ready_q;

    fir_ring_buf #(
        .WIDTH (WIDTH),
        .TAP   (TAP)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .we_i      (accept_s),
        .wr_idx_i  (wr_ptr_q),
        .wr_data_i (sam_in),
        .newest_i  (newest_q),
        .k_i       (k_q),
        .a_o       (a_s),
        .b_o       (b_s)
    );

    // Pre-add the symmetric pair (center tap alone) and accumulate the product.
    always_comb begin
        pre_s = '0;
        if (k_q == K_LAST) begin
            pre_s = PRE_W'(a_s);
        end else begin
            pre_s = PRE_W'(a_s) + PRE_W'(b_s);
        end
        prod_s = ACC_W'(pre_s) * ACC_W'(coef_data);
        acc_d  = acc_q + prod_s;
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    logic signed [ACC_W-1:0] shifted_s;

    // Rescale from Q1.(COF-1) and clamp to the sample range.
    always_comb begin
        shifted_s = acc_d >>> (COF - 1);
        result_s  = '0;
        if (shifted_s > SAT_MAX) begin
            result_s = SAT_MAX[WIDTH-1:0];
        end else if (shifted_s < SAT_MIN) begin
            result_s = SAT_MIN[WIDTH-1:0];
        end else begin
            result_s = shifted_s[WIDTH-1:0];
        end
    end
`else
    // Rescale from Q1.(COF-1); the slice is the wrapped low WIDTH bits.
    always_comb begin
        result_s = acc_d[COF-1 +: WIDTH];
    end
`endif

    // Sequencer: accept a sample, walk k over all pairs, then present the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (accept_s) begin
                        state_q    <= MAC;
                        newest_q   <= wr_ptr_q;
                        wr_ptr_q   <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
                        acc_q      <= '0;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == K_LAST) begin
                        state_q     <= OUT;
                        k_q         <= '0;
                        data_out_q  <= result_s;
                        out_valid_q <= 1'b1;
                    end else begin
                        k_q <= k_q + 6'd1;
                    end
                end
                OUT: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    k_q         <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // k is held at zero outside MAC, so the ROM address is the counter itself.
    assign coef_addr = k_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;

endmodule

// File: doc/fir_fold_sched.md
# fir_fold_sched

Folded symmetric-FIR sequencer for the audio path. It time-shares one pre-adder and one multiply-accumulate unit across all (TAP+1)/2 coefficient positions of each input sample, replacing the fully parallel 51-multiplier tree. It sits between the codec sample stream and the output stage. It owns the sample history ring and addresses the external coefficient ROM.

## Interface
- WIDTH, 24, sample width (signed).
- TAP, 101, filter length; must be odd.
- COF, 24, coefficient width, signed Q1.(COF-1).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sam_in holds a new sample.
- in_ready  out  1  block can accept a sample this cycle.
- sam_in  in  WIDTH  signed input sample.
- coef_addr  out  6  coefficient index k, 0..NPAIR-1.
- coef_data  in  COF  h[k]; combinational ROM, valid in the same cycle as coef_addr.
- out_valid  out  1  one-cycle pulse; data_out holds a new result.
- data_out  out  WIDTH  signed filtered sample.
- busy  out  1  high in MAC and OUT states.

## Operation
- Derived constant NPAIR = (TAP+1)/2, which is 51 at the defaults.
- Accumulator width ACC_W = WIDTH+1+COF+clog2(NPAIR), which is 55 at the defaults.
- States:
  - IDLE: in_ready=1.
  - MAC: k counts 0..NPAIR-1.
  - OUT: out_valid=1.
- IDLE→MAC on in_valid&&in_ready:
  - write sam_in to ring[wr_ptr];
  - newest ← wr_ptr;
  - wr_ptr ← (wr_ptr==TAP-1) ? 0 : wr_ptr+1;
  - acc ← 0, k ← 0.
- In MAC, each cycle:
  - a = ring[(newest−k) mod TAP];
  - b = ring[(newest−(TAP−1−k)) mod TAP];
  - pre = (k==NPAIR−1) ? sext(a) : sext(a)+sext(b), WIDTH+1 bits; the center tap is not doubled;
  - acc ← acc + pre·coef_data, full precision and sign-extended.
- MAC→OUT after the k=NPAIR−1 cycle.
  - data_out ← (acc_final >>> (COF−1)), arithmetic shift, then reduced to WIDTH bits as set under Configuration.
  - out_valid ← 1.
- OUT→IDLE unconditionally after one cycle.
- Modulo indexing wraps below 0 by adding TAP. No divider is used; the index is computed as a conditional subtract.
- in_valid while in_ready=0: the sample is ignored and not stored. The upstream side must hold it.
- No back-pressure on the output. out_valid is a pulse; the consumer must take it.
- coef_addr = k in MAC and 0 otherwise.

## Timing
- Accept edge at T. MAC occupies T+1..T+NPAIR. out_valid=1 during cycle T+NPAIR+1. in_ready=1 again at T+NPAIR+2.
- Latency at defaults: 52 cycles from accept to out_valid. Minimum sample period: 53 cycles.
- data_out holds its value until the next OUT.
- Reset (rst=0, asynchronous):
  - state=IDLE; all ring entries=0; wr_ptr=0, newest=0, k=0, acc=0;
  - in_ready=1 (asserted while in reset); out_valid=0; data_out=0; busy=0; coef_addr=0.
- Reset mid-MAC or mid-OUT: the operation is aborted, no out_valid pulse occurs, and the sample history is lost (zeroed).
- Filling: the first TAP−1 outputs use zero history.

## Configuration
- FIR_SAT_EN defined: the shifted result is saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- FIR_SAT_EN undefined: the low WIDTH bits of the shifted result are taken (two's-complement wrap), with no extra logic.

## Structure
- Package fir_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - the NPAIR and ACC_W localparam functions;
  - a clog2 helper.
- Sub-module fir_ring_buf: TAP×WIDTH register array with async-reset clear, one write port, and two combinational read ports (a/b). It also holds the index-wrap logic.

## Test plan
- Unit impulse: all h=0x000100; sam_in=0x010000 then zeros. Expect outputs 0..100 = 0x000002, output 101 onward = 0.
- Center-tap check: only h[50]=0x400000; impulse 0x200000. Expect 0x100000 only at output 50, all others 0, which confirms the center tap is not doubled.
- Pair check: only h[0]=0x400000; impulse 0x200000. Expect 0x100000 at outputs 0 and 100, 0 elsewhere.
- Negative input: all h=0x400000; impulse 0xC00000. Expect 0xE00000 on outputs 0..100.
- Handshake: in_valid held high. Expect accepts exactly every 53 cycles, in_ready low for 52 cycles, and 1-cycle out_valid at accept+52.
- Reset mid-MAC at k=20, then the unit-impulse test: no out_valid before reset release, in_ready=1 in the first post-reset cycle, and a response identical to the unit-impulse result.
- Saturation: constant 0x7FFFFF with all h=0x7FFFFF. After fill, FIR_SAT_EN gives 0x7FFFFF; without it, the output equals the low 24 bits of acc>>>23.
